// File: rtl/usb_ctrl_out_ep_buf.sv
// Single-buffered OUT/SETUP endpoint buffer: token match, payload capture, ACK/NAK/STALL, pop interface.
// Optional macro USB_OUT_EP_TOGGLE_CHECK_EN enables DATA0/DATA1 duplicate detection.
module usb_ctrl_out_ep_buf #(
  parameter int unsigned EP_NUM       = 0,
  parameter int unsigned MAX_PKT_SIZE = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] dev_addr,
  input  logic       rx_pkt_start,
  input  logic       rx_pkt_end,
  input  logic       rx_pkt_valid,
  input  logic [3:0] rx_pid,
  input  logic [6:0] rx_addr,
  input  logic [3:0] rx_endp,
  input  logic       rx_data_put,
  input  logic [7:0] rx_data,
  output logic       tx_pkt_req,
  output logic [3:0] tx_pid,
  input  logic       out_ep_req,
  output logic       out_ep_grant,
  output logic       out_ep_data_avail,
  output logic       out_ep_setup,
  input  logic       out_ep_data_get,
  output logic [7:0] out_ep_data,
  input  logic       out_ep_stall,
  output logic       out_ep_acked
);

  localparam int unsigned PW = $clog2(MAX_PKT_SIZE + 1);
  localparam int unsigned AW = (MAX_PKT_SIZE > 1) ? $clog2(MAX_PKT_SIZE) : 1;
  localparam logic [3:0]    EP   = 4'(EP_NUM);
  localparam logic [PW-1:0] MAXP = PW'(MAX_PKT_SIZE);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_TOKEN, S_DATA, S_HOLD} state_e;

  state_e        state_q, state_d;
  logic          setup_q, setup_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          nak_tok_q, nak_tok_d;
  logic          nak_dat_q, nak_dat_d;
  logic          tx_req_q, tx_req_d;
  logic [3:0]    tx_pid_q, tx_pid_d;
  logic          acked_q, acked_d;
  logic [7:0]    rd_q, rd_d;
`ifdef USB_OUT_EP_TOGGLE_CHECK_EN
  logic          tog_q, tog_d;
  logic          dtog_q, dtog_d;
`endif

  logic [7:0] buf_mem [MAX_PKT_SIZE];

  logic tok_ok, setup_tok, out_tok, is_data_pid, avail, pop, wr_en;

  assign tok_ok      = rx_pkt_end && rx_pkt_valid && (rx_addr == dev_addr) && (rx_endp == EP);
  assign setup_tok   = tok_ok && (rx_pid == PID_SETUP);
  assign out_tok     = tok_ok && (rx_pid == PID_OUT);
  assign is_data_pid = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
  assign avail       = (state_q == S_HOLD) && (rptr_q < len_q);
  assign pop         = (state_q == S_HOLD) && out_ep_data_get && out_ep_req && avail;

  always_comb begin
    state_d   = state_q;
    setup_d   = setup_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    nak_tok_d = nak_tok_q;
    nak_dat_d = nak_dat_q;
    tx_req_d  = 1'b0;
    tx_pid_d  = tx_pid_q;
    acked_d   = 1'b0;
    rd_d      = rd_q;
    wr_en     = 1'b0;
`ifdef USB_OUT_EP_TOGGLE_CHECK_EN
    tog_d     = tog_q;
    dtog_d    = dtog_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (out_tok) begin
          state_d = S_TOKEN;
          setup_d = 1'b0;
        end
      end
      S_TOKEN: begin
        if (rx_pkt_start) begin
          if (is_data_pid) begin
            state_d = S_DATA;
            wptr_d  = '0;
            ovf_d   = 1'b0;
`ifdef USB_OUT_EP_TOGGLE_CHECK_EN
            dtog_d  = rx_pid[3];
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (rx_data_put) begin
          if (wptr_q < MAXP) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + PW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (rx_pkt_end) begin
          state_d = S_IDLE;
          if (rx_pkt_valid && !ovf_q) begin
            if (!setup_q && out_ep_stall) begin
              tx_req_d = 1'b1;
              tx_pid_d = PID_STALL;
            end else begin
              tx_req_d = 1'b1;
              tx_pid_d = PID_ACK;
              acked_d  = 1'b1;
`ifdef USB_OUT_EP_TOGGLE_CHECK_EN
              if (setup_q) begin
                tog_d = 1'b1;
              end else if (dtog_q != tog_q) begin
                acked_d = 1'b0;
              end else begin
                tog_d = ~tog_q;
              end
`endif
              if (acked_d) begin
                len_d   = wptr_q;
                rptr_d  = '0;
                state_d = (wptr_q == '0) ? S_IDLE : S_HOLD;
              end
            end
          end
        end
      end
      S_HOLD: begin
        if (pop) begin
          rd_d   = buf_mem[rptr_q[AW-1:0]];
          rptr_d = rptr_q + PW'(1);
          if (rptr_q + PW'(1) == len_q) state_d = S_IDLE;
        end
        if (out_tok) nak_tok_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // NAK tracking survives leaving HOLD so the pending data packet still gets its handshake.
    if (nak_tok_q && rx_pkt_start) begin
      nak_tok_d = 1'b0;
      nak_dat_d = is_data_pid;
    end
    if (nak_dat_q && rx_pkt_end) begin
      nak_dat_d = 1'b0;
      if (rx_pkt_valid) begin
        tx_req_d = 1'b1;
        tx_pid_d = PID_NAK;
      end
    end

    if (setup_tok) begin
      state_d   = S_TOKEN;
      setup_d   = 1'b1;
      wptr_d    = '0;
      rptr_d    = '0;
      len_d     = '0;
      ovf_d     = 1'b0;
      nak_tok_d = 1'b0;
      nak_dat_d = 1'b0;
      tx_req_d  = 1'b0;
      tx_pid_d  = tx_pid_q;
      acked_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      setup_q   <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      nak_tok_q <= 1'b0;
      nak_dat_q <= 1'b0;
      tx_req_q  <= 1'b0;
      tx_pid_q  <= '0;
      acked_q   <= 1'b0;
      rd_q      <= '0;
`ifdef USB_OUT_EP_TOGGLE_CHECK_EN
      tog_q     <= 1'b0;
      dtog_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      setup_q   <= setup_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      nak_tok_q <= nak_tok_d;
      nak_dat_q <= nak_dat_d;
      tx_req_q  <= tx_req_d;
      tx_pid_q  <= tx_pid_d;
      acked_q   <= acked_d;
      rd_q      <= rd_d;
`ifdef USB_OUT_EP_TOGGLE_CHECK_EN
      tog_q     <= tog_d;
      dtog_q    <= dtog_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wptr_q[AW-1:0]] <= rx_data;
  end

  assign tx_pkt_req        = tx_req_q;
  assign tx_pid            = tx_pid_q;
  assign out_ep_grant      = (state_q == S_HOLD) && out_ep_req;
  assign out_ep_data_avail = avail;
  assign out_ep_setup      = (state_q == S_HOLD) && setup_q;
  assign out_ep_data       = rd_q;
  assign out_ep_acked      = acked_q;

endmodule

// File: doc/usb_ctrl_out_ep_buf.md
Name: usb_ctrl_out_ep_buf

Overview:
Single-buffered OUT/SETUP endpoint buffer between the USB protocol receive engine and the control endpoint state machine. It matches tokens to the device address and endpoint, captures DATA0/DATA1 payloads and checks data toggle. It generates the ACK/NAK/STALL handshake, then presents the packet to the control endpoint through the out_ep_* req/grant/get interface.

Parameters:
EP_NUM, 0, endpoint number matched against rx_endp.
MAX_PKT_SIZE, 32, buffer depth in bytes; larger payloads are discarded with no handshake.

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
dev_addr  in  7  current device address
rx_pkt_start  in  1  1-cycle pulse, packet begins
rx_pkt_end  in  1  1-cycle pulse, packet ends
rx_pkt_valid  in  1  CRC/PID ok; sampled with rx_pkt_end
rx_pid  in  4  PID; valid from rx_pkt_start to rx_pkt_end
rx_addr  in  7  token address; valid at rx_pkt_end
rx_endp  in  4  token endpoint; valid at rx_pkt_end
rx_data_put  in  1  payload byte strobe, CRC bytes excluded
rx_data  in  8  payload byte
tx_pkt_req  out  1  1-cycle pulse, send handshake
tx_pid  out  4  handshake PID, held from tx_pkt_req until next request
out_ep_req  in  1  endpoint requests buffer access
out_ep_grant  out  1  access granted
out_ep_data_avail  out  1  unread bytes present
out_ep_setup  out  1  buffered packet is SETUP data
out_ep_data_get  in  1  pop strobe
out_ep_data  out  8  popped byte
out_ep_stall  in  1  endpoint requests STALL on OUT
out_ep_acked  out  1  1-cycle pulse, ACK issued for accepted data

Behaviour:
- Reset values:
  - all outputs 0; tx_pid = 4'b0000
  - state IDLE, buffer empty, expected toggle DATA0
- PIDs: OUT 0001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
- Token match: rx_pkt_end && rx_pkt_valid && rx_addr == dev_addr && rx_endp == EP_NUM. Unmatched or invalid tokens are ignored.
- States: IDLE, TOKEN, DATA, HOLD.
- IDLE:
  - matched OUT -> TOKEN, setup_flag = 0
  - matched SETUP -> TOKEN, setup_flag = 1
- TOKEN:
  - rx_pkt_start with DATA0/1 -> DATA, write pointer cleared
  - any other PID or token -> IDLE, no handshake
- DATA:
  - each rx_data_put writes buffer[wptr], wptr++
  - beyond MAX_PKT_SIZE bytes sets overflow; further bytes dropped
- DATA end (rx_pkt_end):
  - invalid or overflow -> IDLE, no handshake, buffer empty
  - OUT with out_ep_stall = 1 -> STALL, IDLE
  - SETUP: always ACK; toggle forced to DATA1 afterwards; accept
  - OUT with PID toggle != expected -> ACK, discard (duplicate), IDLE
  - OUT otherwise -> ACK, flip expected toggle, accept
  - accept -> HOLD, len = wptr; out_ep_acked pulses in the same cycle as tx_pkt_req
  - zero-length accepted packet -> ACK, out_ep_acked, back to IDLE (avail never asserts)
- HOLD:
  - out_ep_grant = out_ep_req; out_ep_data_avail = (rptr < len); out_ep_setup = setup_flag
  - pop on out_ep_data_get && out_ep_grant && out_ep_data_avail; out_ep_data valid the cycle after the pop (registered read); rptr++
  - rptr == len -> IDLE; avail falls on the cycle of the last pop
- Handshake latency: tx_pkt_req asserts exactly 1 cycle after rx_pkt_end.
- Matched OUT in HOLD -> NAK after its data packet ends; data discarded; buffer untouched.
- Matched SETUP in any state, including HOLD/DATA, takes priority:
  - flushes the buffer, goes to TOKEN
  - setup_flag = 1; a subsequent valid SETUP DATA0 overwrites the buffer
- Simultaneous pop and reset: reset wins.
- Reset mid-packet: state IDLE, buffer empty, no handshake emitted.

Optional Feature:
USB_OUT_EP_TOGGLE_CHECK_EN:
- Defined: DATA-end duplicate detection as above.
- Undefined: toggle is not tracked; every valid, non-overflow, non-stalled packet is ACKed and accepted regardless of DATA0/DATA1.

Test Plan:
1. SETUP addr 0 ep 0 + DATA0 of 8 bytes 80 06 00 01 00 00 12 00 -> ACK 1 cycle after end; out_ep_acked pulse; avail=1, setup=1; 8 pops return the same bytes, avail drops on 8th pop.
2. After SETUP, OUT + DATA1 (4 bytes) -> ACK, accepted. OUT + DATA1 repeated -> ACK, avail stays 0, no out_ep_acked.
3. Buffer held unread (HOLD), OUT + DATA0 -> NAK; original bytes still readable intact.
4. out_ep_stall=1, OUT + DATA1 -> tx_pid=1110; no data available. SETUP during HOLD -> buffer flushed, new SETUP data delivered.
5. DATA0 of 33 bytes -> no tx_pkt_req, avail=0. rx_pkt_valid=0 -> no handshake. Token with rx_addr=5 while dev_addr=0 -> ignored.
6. Reset asserted after 3 of 8 data bytes -> no handshake; next OUT uses expected DATA0. With macro undefined, repeated DATA1 packets both accepted.
